// File: rtl/dev_ram_mp.sv
// Multi-port big-endian quad RAM: round-robin grants one byte/word/long/quad access
// per cycle, responses come one cycle after acceptance.
module dev_ram_mp #(
    parameter int NPORTS     = 2,
    parameter int ADDRW      = 16,
    parameter int QUAD_BYTES = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NPORTS-1:0]              req_valid,
    output logic [NPORTS-1:0]              req_ready,
    input  logic [NPORTS-1:0]              req_we,
    input  logic [2*NPORTS-1:0]            req_size,
    input  logic [ADDRW*NPORTS-1:0]        req_addr,
    input  logic [QUAD_BYTES*8*NPORTS-1:0] req_wdata,
    output logic [NPORTS-1:0]              resp_valid,
    output logic [NPORTS-1:0]              resp_err,
    output logic [QUAD_BYTES*8*NPORTS-1:0] resp_rdata
);
    localparam int DW    = QUAD_BYTES * 8;
    localparam int OW    = $clog2(QUAD_BYTES);
    localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;
    localparam int DEPTH = 1 << (ADDRW - OW);

    function automatic logic [DW-1:0] size_mask(input logic [1:0] sz);
        logic [DW-1:0] m;
        m = '0;
        for (int b = 0; b < QUAD_BYTES; b++)
            if (b < (1 << sz)) m[b*8 +: 8] = 8'hFF;
        return m;
    endfunction

    logic [DW-1:0]         mem [DEPTH];
    logic [PW-1:0]         last_grant;
    logic [PW-1:0]         gidx;
    logic                  accept;
    logic [NPORTS-1:0]     gnt;

    logic                  sel_we;
    logic [1:0]            sel_size;
    logic [ADDRW-1:0]      sel_addr;
    logic [DW-1:0]         sel_wdata;
    logic [OW-1:0]         off;
    logic [OW:0]           nbytes;
    logic [OW:0]           lane_lo;
    logic                  mis;
    logic [QUAD_BYTES-1:0] be;
    logic [DW-1:0]         wquad;
    logic [ADDRW-OW-1:0]   qaddr;

    logic                  rd_valid;
    logic [PW-1:0]         rd_port;
    logic                  rd_err;
    logic                  rd_we;
    logic [1:0]            rd_size;
    logic [OW:0]           rd_lane;
    logic [DW-1:0]         rd_quad;
    logic [DW-1:0]         ld_data;

    // Round-robin search starting one past the last accepted port.
    always_comb begin
        int j;
        j      = 0;
        gidx   = '0;
        accept = 1'b0;
        gnt    = '0;
        for (int i = 0; i < NPORTS; i++) begin
            j = int'(last_grant) + 1 + i;
            if (j >= NPORTS) j = j - NPORTS;
            if (j >= NPORTS) j = j - NPORTS;
            if (!accept && req_valid[j]) begin
                accept = 1'b1;
                gidx   = PW'(j);
            end
        end
        if (rst) accept = 1'b0;
        if (accept) gnt[gidx] = 1'b1;
    end

    assign req_ready = gnt;

    always_comb begin
        sel_we    = req_we[gidx];
        sel_size  = req_size[int'(gidx)*2 +: 2];
        sel_addr  = req_addr[int'(gidx)*ADDRW +: ADDRW];
        sel_wdata = req_wdata[int'(gidx)*DW +: DW];
        off       = sel_addr[OW-1:0];
        qaddr     = sel_addr[ADDRW-1:OW];
        nbytes    = (OW+1)'(1) << sel_size;
        mis       = |(off & OW'(nbytes - (OW+1)'(1)));
        // Lane 0 is the least significant byte, so offset 0 lives in the top lane.
        lane_lo   = (OW+1)'(QUAD_BYTES) - {1'b0, off} - nbytes;
        wquad     = (sel_wdata & size_mask(sel_size)) << {lane_lo, 3'b000};
        be        = '0;
        for (int b = 0; b < QUAD_BYTES; b++)
            be[b] = !mis && (b >= int'(lane_lo)) && (b < int'(lane_lo) + int'(nbytes));
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            if (sel_we) begin
                for (int b = 0; b < QUAD_BYTES; b++)
                    if (be[b]) mem[qaddr][b*8 +: 8] <= wquad[b*8 +: 8];
            end
            rd_quad <= mem[qaddr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= PW'(NPORTS - 1);
            rd_valid   <= 1'b0;
            rd_port    <= '0;
            rd_err     <= 1'b0;
            rd_we      <= 1'b0;
            rd_size    <= '0;
            rd_lane    <= '0;
        end else begin
            rd_valid <= accept;
            if (accept) begin
                last_grant <= gidx;
                rd_port    <= gidx;
                rd_err     <= mis;
                rd_we      <= sel_we;
                rd_size    <= sel_size;
                rd_lane    <= lane_lo;
            end
        end
    end

    always_comb begin
        ld_data    = (rd_quad >> {rd_lane, 3'b000}) & size_mask(rd_size);
        resp_valid = '0;
        resp_err   = '0;
        resp_rdata = '0;
        if (rd_valid) begin
            resp_valid[rd_port] = 1'b1;
            resp_err[rd_port]   = rd_err;
            if (!rd_err && !rd_we) resp_rdata[int'(rd_port)*DW +: DW] = ld_data;
        end
    end
endmodule

// File: tb/tb_dev_ram_mp.sv
// Directed bench for dev_ram_mp with two ports: byte lanes, misalignment,
// round-robin, read-after-write and reset during a granted load.
module tb_dev_ram_mp;
    localparam int NP = 2;
    localparam int AW = 16;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NP-1:0]        req_valid, req_ready, req_we, resp_valid, resp_err;
    logic [2*NP-1:0]      req_size;
    logic [AW*NP-1:0]     req_addr;
    logic [64*NP-1:0]     req_wdata, resp_rdata;
    int                   errors = 0;
    int                   checks = 0;

    always #5 clk = ~clk;

    dev_ram_mp #(.NPORTS(NP), .ADDRW(AW), .QUAD_BYTES(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata)
    );

    task automatic set_req(input int p, input logic we, input logic [1:0] sz,
                           input logic [AW-1:0] a, input logic [63:0] wd);
        req_valid[p]           = 1'b1;
        req_we[p]              = we;
        req_size[p*2 +: 2]     = sz;
        req_addr[p*AW +: AW]   = a;
        req_wdata[p*64 +: 64]  = wd;
    endtask

    // Single uncontested access; starts and ends just after a rising edge.
    task automatic access(input int p, input logic we, input logic [1:0] sz,
                          input logic [AW-1:0] a, input logic [63:0] wd,
                          output logic rdy, output logic rv, output logic re,
                          output logic [63:0] rd);
        set_req(p, we, sz, a, wd);
        @(negedge clk);
        rdy = req_ready[p];
        @(posedge clk); #1;
        req_valid[p] = 1'b0;
        @(negedge clk);
        rv = resp_valid[p];
        re = resp_err[p];
        rd = resp_rdata[p*64 +: 64];
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #1 req_valid = 2'b11;
        #2;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL reset_resp_valid: got %b want 00", resp_valid); end
        checks++; if (resp_err !== 2'b00) begin errors++; $display("FAIL reset_resp_err: got %b want 00", resp_err); end
        checks++; if (resp_rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
        req_valid = 2'b00;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic rdy, rv, re; logic [63:0] rd;
        logic [1:0]  sz [5] = '{2'd3, 2'd0, 2'd0, 2'd1, 2'd2};
        logic [15:0] ad [5] = '{16'h0010, 16'h0010, 16'h0017, 16'h0012, 16'h0014};
        logic [63:0] ex [5] = '{64'h0, 64'h01, 64'hEF, 64'h4567, 64'h89ABCDEF};
        for (int i = 0; i < 5; i++) begin
            access(0, i == 0, sz[i], ad[i], 64'h0123456789ABCDEF, rdy, rv, re, rd);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL sl_ready[%0d]: got %b want 1", i, rdy); end
            checks++; if (rv !== 1'b1 || re !== 1'b0) begin errors++; $display("FAIL sl_resp[%0d]: valid %b err %b want 1 0", i, rv, re); end
            checks++; if (rd !== ex[i]) begin errors++; $display("FAIL sl_rdata[%0d]: got %h want %h", i, rd, ex[i]); end
        end
    endtask

    task automatic test_byte_merge();
        logic rdy, rv, re; logic [63:0] rd;
        access(0, 1'b1, 2'd0, 16'h0013, 64'hAA, rdy, rv, re, rd);
        checks++; if (rv !== 1'b1 || re !== 1'b0 || rd !== 64'h0) begin errors++; $display("FAIL merge_store_ack: valid %b err %b rdata %h", rv, re, rd); end
        access(0, 1'b0, 2'd3, 16'h0010, 64'h0, rdy, rv, re, rd);
        checks++; if (rd !== 64'h012345AA89ABCDEF) begin errors++; $display("FAIL merge_quad: got %h want 012345aa89abcdef", rd); end
    endtask

    task automatic test_misaligned();
        logic rdy, rv, re; logic [63:0] rd;
        access(0, 1'b0, 2'd1, 16'h0011, 64'h0, rdy, rv, re, rd);
        checks++; if (rv !== 1'b1 || re !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL mis_load: valid %b err %b rdata %h want 1 1 0", rv, re, rd); end
        access(0, 1'b1, 2'd2, 16'h0016, 64'hFFFFFFFF, rdy, rv, re, rd);
        checks++; if (rv !== 1'b1 || re !== 1'b1 || rd !== 64'h0) begin errors++; $display("FAIL mis_store: valid %b err %b rdata %h want 1 1 0", rv, re, rd); end
        access(0, 1'b0, 2'd3, 16'h0010, 64'h0, rdy, rv, re, rd);
        checks++; if (rd !== 64'h012345AA89ABCDEF || re !== 1'b0) begin errors++; $display("FAIL mis_unchanged: got %h err %b", rd, re); end
    endtask

    task automatic test_alternate();
        logic [1:0]  eg [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [63:0] ed [4] = '{64'h012345AA, 64'h45AA, 64'h012345AA, 64'h45AA};
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'd2, 16'h0010, 64'h0);
        set_req(1, 1'b0, 2'd1, 16'h0012, 64'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k < 4) begin
                checks++; if (req_ready !== eg[k]) begin errors++; $display("FAIL rr_grant[%0d]: got %b want %b", k, req_ready, eg[k]); end
            end
            if (k > 0) begin
                checks++; if (resp_valid !== eg[k-1]) begin errors++; $display("FAIL rr_resp_valid[%0d]: got %b want %b", k, resp_valid, eg[k-1]); end
                checks++; if (resp_rdata[(k-1)%2*64 +: 64] !== ed[k-1]) begin errors++; $display("FAIL rr_rdata[%0d]: got %h want %h", k, resp_rdata[(k-1)%2*64 +: 64], ed[k-1]); end
            end
            @(posedge clk); #1;
            if (k == 3) req_valid = 2'b00;
        end
    endtask

    task automatic test_raw();
        set_req(1, 1'b1, 2'd1, 16'h0020, 64'h5A5A);
        @(negedge clk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL raw_store_grant: got %b want 10", req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(0, 1'b0, 2'd1, 16'h0020, 64'h0);
        @(negedge clk);
        checks++; if (resp_valid !== 2'b10 || resp_err !== 2'b00) begin errors++; $display("FAIL raw_store_ack: valid %b err %b want 10 00", resp_valid, resp_err); end
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL raw_load_grant: got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b01 || resp_rdata[63:0] !== 64'h5A5A) begin errors++; $display("FAIL raw_load: valid %b rdata %h want 01 5a5a", resp_valid, resp_rdata[63:0]); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        set_req(0, 1'b0, 2'd3, 16'h0010, 64'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_grant: got %b want 01", req_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL rm_ready_in_reset: got %b want 00", req_ready); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b00) begin errors++; $display("FAIL rm_dropped: got %b want 00", resp_valid); end
        rst = 1'b0;
        @(posedge clk); #1;
        set_req(0, 1'b0, 2'd3, 16'h0010, 64'h0);
        set_req(1, 1'b0, 2'd1, 16'h0020, 64'h0);
        @(negedge clk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rm_first_grant: got %b want 01", req_ready); end
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b01 || resp_rdata[63:0] !== 64'h012345AA89ABCDEF) begin errors++; $display("FAIL rm_retained: valid %b rdata %h", resp_valid, resp_rdata[63:0]); end
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL rm_second_grant: got %b want 10", req_ready); end
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        checks++; if (resp_valid !== 2'b10 || resp_rdata[127:64] !== 64'h5A5A) begin errors++; $display("FAIL rm_port1: valid %b rdata %h", resp_valid, resp_rdata[127:64]); end
        @(posedge clk); #1;
    endtask

    initial begin
        req_valid = '0; req_we = '0; req_size = '0; req_addr = '0; req_wdata = '0;
        test_reset();
        test_store_load();
        test_byte_merge();
        test_misaligned();
        test_alternate();
        test_raw();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
